// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Quotient goes to the LO write port and remainder to the HI write port,
// both strobed for one cycle. busy covers the whole operation so dependent
// MFHI/MFLO can stall until the write has landed.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, is_signed          launch request and DIV(1)/DIVU(0) select
//   dividend, divisor         operands, sampled with an accepted start
//   cancel                    flush: abort the operation, suppress the write
//   busy                      high from the cycle after accept through DONE
//   wLoData, wlo              quotient and LO write strobe
//   wHiData, whi              remainder and HI write strobe
//   div_by_zero               qualifies the write: divisor was zero
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              cancel,
  output logic              busy,
  output logic [DATA_W-1:0] wLoData,
  output logic              wlo,
  output logic [DATA_W-1:0] wHiData,
  output logic              whi,
  output logic              div_by_zero
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;   // partial remainder
  logic [DATA_W-1:0]   quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]   dvs_q, dvs_d;   // divisor magnitude
  logic                neg_q, neg_d;   // negate quotient
  logic                rneg_q, rneg_d; // negate remainder
  logic                dbz_q, dbz_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;

  // One restoring step: bring in the next dividend bit, trial-subtract.
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   q_next;
  logic [DATA_W-1:0]   r_next;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic                sgn_a;
  logic                sgn_b;

  always_comb begin
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    // diff[DATA_W] is the borrow: set means the trial subtraction failed
    q_next = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
    r_next = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
  end

  // Operand magnitudes; INT_MIN maps to 2^(DATA_W-1) which fits unsigned.
  always_comb begin
    sgn_a = is_signed & dividend[DATA_W-1];
    sgn_b = is_signed & divisor[DATA_W-1];
    mag_a = sgn_a ? -dividend : dividend;
    mag_b = sgn_b ? -divisor  : divisor;
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    lo_d    = lo_q;
    hi_d    = hi_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = mag_a;
          dvs_d  = mag_b;
          neg_d  = sgn_a ^ sgn_b;
          rneg_d = sgn_a;
          dbz_d  = (divisor == '0);
          if (divisor == '0) begin
            lo_d    = '1;
            hi_d    = dividend;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          rem_d = r_next;
          quo_d = q_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            lo_d    = neg_q  ? -q_next : q_next;
            hi_d    = rneg_q ? -r_next : r_next;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Strobes decode from state; cancel in DONE kills the write combinationally.
  assign busy        = (state_q != S_IDLE);
  assign wlo         = (state_q == S_DONE) && !cancel;
  assign whi         = wlo;
  assign div_by_zero = wlo && dbz_q;
  assign wLoData     = lo_q;
  assign wHiData     = hi_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with hand-computed results.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        busy;
  logic [31:0] wLoData;
  logic        wlo;
  logic [31:0] wHiData;
  logic        whi;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .cancel      (cancel),
    .busy        (busy),
    .wLoData     (wLoData),
    .wlo         (wlo),
    .wHiData     (wHiData),
    .whi         (whi),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds start for the current cycle N; returns in cycle N+1.
  task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b);
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Launches, waits (bounded) for the write strobe, checks latency and data.
  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo,
                         input logic [31:0] ehi, input logic edbz);
    int lat;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 1 : 33;
    launch(sg, a, b);
    lat = 1;
    while (!wlo && lat < 50) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " whi"}, 32'(whi), 32'd1);
    check({tag, " lo"}, wLoData, elo);
    check({tag, " hi"}, wHiData, ehi);
    check({tag, " dbz"}, 32'(div_by_zero), 32'(edbz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    cancel    = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst busy", 32'(busy), 32'd0);
    check("rst wlo", 32'(wlo), 32'd0);
    check("rst whi", 32'(whi), 32'd0);
    check("rst dbz", 32'(div_by_zero), 32'd0);
    check("rst lo", wLoData, 32'd0);
    check("rst hi", wHiData, 32'd0);

    // DIVU 100/7 with cycle-exact strobe and busy window
    launch(1'b0, 32'd100, 32'd7);
    for (int c = 1; c <= 33; c++) begin
      check($sformatf("t1 busy c%0d", c), 32'(busy), 32'd1);
      check($sformatf("t1 wlo c%0d", c), 32'(wlo), 32'(c == 33));
      check($sformatf("t1 whi c%0d", c), 32'(whi), 32'(c == 33));
      if (c < 33) step();
    end
    check("t1 lo", wLoData, 32'd14);
    check("t1 hi", wHiData, 32'd2);
    step();
    check("t1 busy after", 32'(busy), 32'd0);
    check("t1 wlo after", 32'(wlo), 32'd0);

    // Signed cases
    run_div("t2 -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    step();
    run_div("t2 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    step();
    run_div("t2 -7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
    step();

    // Boundaries
    run_div("t3 intmin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    step();
    run_div("t3 max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    step();
    run_div("t3 divu big", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    step();

    // Divide by zero
    run_div("t4 div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    step();
    run_div("t4 divu 1234/0", 1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
    step();
    check("t4 busy N+2", 32'(busy), 32'd0);
    check("t4 dbz N+2", 32'(div_by_zero), 32'd0);

    // Ignored start while busy, cancel mid-CALC
    launch(1'b0, 32'd100, 32'd7);          // now N+1
    for (int i = 0; i < 4; i++) step();    // N+5
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    step();                                // N+6
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();    // N+10
    cancel = 1'b1;
    step();                                // N+11
    cancel = 1'b0;
    check("t5 busy N+11", 32'(busy), 32'd0);
    check("t5 lo hold", wLoData, 32'hFFFF_FFFF);
    check("t5 hi hold", wHiData, 32'd1234);
    seen = 0;
    for (int c = 11; c <= 40; c++) begin
      if (wlo || whi || busy) seen++;
      if (c < 40) step();
    end
    check("t5 quiet to N+40", 32'(seen), 32'd0);
    step();
    run_div("t5 50/5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    step();

    // start+cancel together in IDLE: nothing launched
    is_signed = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd3;
    start     = 1'b1;
    cancel    = 1'b1;
    step();
    start  = 1'b0;
    cancel = 1'b0;
    check("sc busy", 32'(busy), 32'd0);
    step();
    check("sc wlo", 32'(wlo), 32'd0);

    // cancel in DONE gates the strobes
    launch(1'b0, 32'd77, 32'd0);           // DONE now
    check("cd wlo pre", 32'(wlo), 32'd1);
    cancel = 1'b1;
    #1;
    check("cd wlo", 32'(wlo), 32'd0);
    check("cd whi", 32'(whi), 32'd0);
    step();
    cancel = 1'b0;
    check("cd busy", 32'(busy), 32'd0);
    check("cd wlo after", 32'(wlo), 32'd0);

    // Reset mid-CALC
    launch(1'b0, 32'd100, 32'd7);          // N+1
    for (int i = 0; i < 19; i++) step();   // N+20
    check("t6 busy N+20", 32'(busy), 32'd1);
    rst = 1'b1;
    step();                                // N+21
    rst = 1'b0;
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 wlo", 32'(wlo), 32'd0);
    check("t6 whi", 32'(whi), 32'd0);
    check("t6 dbz", 32'(div_by_zero), 32'd0);
    check("t6 lo", wLoData, 32'd0);
    check("t6 hi", wHiData, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (wlo || busy) seen++;
    end
    check("t6 no write", 32'(seen), 32'd0);

    // Back-to-back: second start in the IDLE cycle right after DONE
    run_div("b2b 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    step();
    check("b2b idle busy", 32'(busy), 32'd0);
    run_div("b2b 8/3", 1'b0, 32'd8, 32'd3, 32'd2, 32'd2, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
